multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core. It owns the program counter and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It classifies the `opcode`/`base` fields produced by the instruction field decoder and drives the datapath enables plus a single shared req/ack memory port. Illegal encodings and memory timeouts park the core in a sticky TRAP state.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/opcode_class.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode codes, FSM state encoding and
// the opcode-class bundle used by multicycle_ctrl.
package ctrl_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic legal;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic writes_rd;
  } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// opcode_class: combinational RV32I opcode classifier.
// Ports: opcode_i[4:0], base_i[1:0] in; cls_o (op_class_t) out.
module opcode_class
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic [1:0] base_i,
  output op_class_t  cls_o
);

  always_comb begin
    cls_o = '0;
    unique case (opcode_i)
      OPC_LOAD: begin
        cls_o.legal     = 1'b1;
        cls_o.is_load   = 1'b1;
        cls_o.writes_rd = 1'b1;
      end
      OPC_STORE: begin
        cls_o.legal    = 1'b1;
        cls_o.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        cls_o.legal     = 1'b1;
        cls_o.is_branch = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        cls_o.legal     = 1'b1;
        cls_o.is_jump   = 1'b1;
        cls_o.writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_AUIPC,
      OPC_OP, OPC_LUI: begin
        cls_o.legal     = 1'b1;
        cls_o.writes_rd = 1'b1;
      end
      OPC_MISC_MEM: begin
        cls_o.legal = 1'b1;
      end
      default: cls_o = '0;
    endcase
    // compressed / non-32-bit encodings are never legal
    if (base_i != 2'b11) cls_o = '0;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC.
// In: clk, rst, opcode, base, branch_taken, target_pc, mem_ack.
// Out: pc, mem_req/we/sel, ir_we, rf_we, illegal, timeout, state.
// Optional memory watchdog: define MULTICYCLE_CTRL_TIMEOUT_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE      = 32,
  parameter int unsigned WORD_SIZE      = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           opcode,
  input  logic [1:0]           base,
  input  logic                 branch_taken,
  input  logic [ADDR_SIZE-1:0] target_pc,
  input  logic                 mem_ack,
  output logic [ADDR_SIZE-1:0] pc,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_sel,
  output logic                 ir_we,
  output logic                 rf_we,
  output logic                 illegal,
  output logic                 timeout,
  output logic [2:0]           state
);

  state_e               state_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] pc_d;
  op_class_t            cls;
  op_class_t            cls_q;
  logic                 illegal_q;
  logic                 timeout_q;
  logic                 wd_expire;
  logic                 unused_cfg;

  assign unused_cfg = ^{32'(WORD_SIZE),
                        32'(TIMEOUT_CYCLES)};

  opcode_class u_cls (
    .opcode_i (opcode),
    .base_i   (base),
    .cls_o    (cls)
  );

  // PC value taken on any instruction-exit edge
  always_comb begin
    pc_d = pc_q + ADDR_SIZE'(PC_STEP);
    if (cls_q.is_jump)
      pc_d = target_pc;
    else if (cls_q.is_branch && branch_taken)
      pc_d = target_pc;
  end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  logic [7:0] wcnt_q;
  logic [7:0] wcnt_d;
  logic       waiting;

  assign waiting = (state_q == ST_FETCH) ||
                   (state_q == ST_MEM);

  // any non-waiting cycle or an ack rearms the count,
  // so it always starts at zero on FETCH/MEM entry
  always_comb begin
    wcnt_d = '0;
    if (waiting && !mem_ack) wcnt_d = wcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end

  assign wd_expire = waiting && !mem_ack &&
    (wcnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      cls_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (mem_ack) begin
            state_q <= ST_DECODE;
          end else if (wd_expire) begin
            state_q   <= ST_TRAP;
            timeout_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (cls.legal) begin
            cls_q   <= cls;
            state_q <= ST_EXEC;
          end else begin
            state_q   <= ST_TRAP;
            illegal_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cls_q.is_load || cls_q.is_store) begin
            state_q <= ST_MEM;
          end else if (cls_q.writes_rd) begin
            state_q <= ST_WB;
          end else begin
            state_q <= ST_FETCH;
            pc_q    <= pc_d;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (cls_q.is_load) begin
              state_q <= ST_WB;
            end else begin
              state_q <= ST_FETCH;
              pc_q    <= pc_d;
            end
          end else if (wd_expire) begin
            state_q   <= ST_TRAP;
            timeout_q <= 1'b1;
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
          pc_q    <= pc_d;
        end
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  // enables are gated by rst so nothing fires in a reset cycle
  assign mem_req = !rst && ((state_q == ST_FETCH) ||
                            (state_q == ST_MEM));
  assign mem_sel = !rst && (state_q == ST_MEM);
  assign mem_we  = !rst && (state_q == ST_MEM) &&
                   cls_q.is_store;
  assign ir_we   = !rst && (state_q == ST_FETCH) && mem_ack;
  assign rf_we   = !rst && (state_q == ST_WB);

  assign pc      = pc_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized scoreboard bench for multicycle_ctrl.
// Driver pushes per-instruction expectations; monitor checks on ir_we.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  opcode = '0;
  logic [1:0]  base = 2'b11;
  logic        branch_taken = 1'b0;
  logic [31:0] target_pc = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] pc;
  logic        mem_req, mem_we, mem_sel;
  logic        ir_we, rf_we, illegal, timeout;
  logic [2:0]  state;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .base         (base),
    .branch_taken (branch_taken),
    .target_pc    (target_pc),
    .mem_ack      (mem_ack),
    .pc           (pc),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .ir_we        (ir_we),
    .rf_we        (rf_we),
    .illegal      (illegal),
    .timeout      (timeout),
    .state        (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef enum {K_ALU, K_LOAD, K_STORE, K_BRANCH,
                K_JUMP, K_FENCE, K_ILL} kind_e;

  typedef struct {
    bit          trap;
    logic [31:0] pc;
    int          lat;
    int          wb;
    int          dcyc;
    bit          we;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pc_m;

  function automatic kind_e kind_of(logic [4:0] op,
                                    logic [1:0] b);
    if (b != 2'b11) return K_ILL;
    case (op)
      5'b00000: return K_LOAD;
      5'b01000: return K_STORE;
      5'b11000: return K_BRANCH;
      5'b11001, 5'b11011: return K_JUMP;
      5'b00011: return K_FENCE;
      5'b00100, 5'b00101,
      5'b01100, 5'b01101: return K_ALU;
      default: return K_ILL;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic bound_fail(string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && (mem_sel == sel)) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    bound_fail(sel ? "wait_mem_req" : "wait_fetch_req");
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 40; i++) begin
      if (state == 3'd0) return;
      tick();
    end
    bound_fail("wait_fetch_state");
  endtask

  task automatic issue(logic [4:0] op, logic [1:0] b,
                       bit bt, logic [31:0] tgt,
                       int fw, int mw, bit spur);
    kind_e k;
    exp_t  e;
    bit    ok;
    k = kind_of(op, b);
    opcode = op;
    base = b;
    branch_taken = bt;
    target_pc = tgt;
    e.trap = (k == K_ILL);
    e.we   = (k == K_STORE);
    e.dcyc = (k == K_LOAD || k == K_STORE) ? mw : 0;
    e.wb   = (k == K_ALU || k == K_JUMP ||
              k == K_LOAD) ? 1 : 0;
    e.lat  = 3 + e.dcyc + e.wb;
    case (k)
      K_JUMP:   e.pc = tgt;
      K_BRANCH: e.pc = bt ? tgt : pc_m + 32'd4;
      default:  e.pc = pc_m + 32'd4;
    endcase
    if (!e.trap) pc_m = e.pc;
    exp_q.push_back(e);
    wait_req(1'b0, ok);
    if (!ok) return;
    repeat (fw) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = spur;
    tick();
    mem_ack = 1'b0;
    if (e.trap) return;
    if (e.dcyc > 0) begin
      wait_req(1'b1, ok);
      if (!ok) return;
      repeat (mw - 1) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    wait_fetch();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    tick();
    tick();
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_enables",
          {mem_req, mem_we, mem_sel, ir_we, rf_we}, 5'd0);
    check("rst_flags", {illegal, timeout}, 2'd0);
    pc_m = 32'h0;
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("req_after_rst", mem_req, 1'b1);
  endtask

  // monitor / scoreboard
  exp_t cur;
  bit   active = 1'b0;
  int   c, rfc, dc, web;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (active) begin
          c++;
          if (rf_we) rfc++;
          if (mem_req && mem_sel) begin
            dc++;
            if (mem_we !== cur.we) web++;
          end
          if (cur.trap) begin
            if (c == 2) begin
              check("trap_state", state, 3'd5);
              check("trap_illegal", illegal, 1'b1);
              check("trap_rf_we", rfc, 0);
              active = 1'b0;
            end
          end else if (state == 3'd0) begin
            check("latency", c, cur.lat);
            check("rf_we_count", rfc, cur.wb);
            check("data_cycles", dc, cur.dcyc);
            check("mem_we", web, 0);
            check("pc_next", pc, cur.pc);
            active = 1'b0;
          end else if (c > 60) begin
            bound_fail("instr_retire");
            active = 1'b0;
          end
        end
        if (ir_we) begin
          if (exp_q.size() == 0) begin
            bound_fail("unexpected_ir_we");
          end else begin
            cur = exp_q.pop_front();
            active = 1'b1;
            c = 0;
            rfc = 0;
            dc = 0;
            web = 0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  logic [4:0] legal_ops [10] = '{
    5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000,
    5'b01100, 5'b01101, 5'b11000, 5'b11001, 5'b11011
  };

  initial begin
    #2;
    do_reset();
    // ADDI, ack on first request cycle
    issue(5'b00100, 2'b11, 1'b0, 32'h0, 0, 1, 1'b0);
    tick();
    check("addi_pc", pc, 32'h4);
    // branch taken / not taken
    issue(5'b11000, 2'b11, 1'b1, 32'h40, 0, 1, 1'b0);
    issue(5'b11000, 2'b11, 1'b0, 32'h80, 1, 1, 1'b0);
    // load with 3-cycle memory wait, then store
    issue(5'b00000, 2'b11, 1'b0, 32'h0, 0, 3, 1'b0);
    issue(5'b01000, 2'b11, 1'b0, 32'h0, 2, 1, 1'b1);
    // jump to top of address space, then wrap
    issue(5'b11011, 2'b11, 1'b0, 32'hFFFF_FFFC, 0, 1, 1'b0);
    issue(5'b01100, 2'b11, 1'b0, 32'h0, 0, 1, 1'b0);
    tick();
    check("pc_wrap", pc, 32'h0);
    // randomized legal traffic
    for (int n = 0; n < 150; n++) begin
      logic [31:0] tgt;
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFFC;
      issue(legal_ops[$urandom_range(0, 9)], 2'b11,
            1'($urandom_range(0, 1)), tgt,
            $urandom_range(0, 3), $urandom_range(1, 4),
            1'($urandom_range(0, 1)));
    end
    // reset during MEM with ack in the reset cycle
    begin
      exp_t e;
      bit   ok;
      opcode = 5'b00000;
      base = 2'b11;
      e.trap = 1'b0;
      e.pc = '0;
      e.lat = 0;
      e.wb = 0;
      e.dcyc = 0;
      e.we = 1'b0;
      exp_q.push_back(e);
      wait_req(1'b0, ok);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      wait_req(1'b1, ok);
      rst = 1'b1;
      mem_ack = 1'b1;
      #1;
      check("midrst_rf_we", rf_we, 1'b0);
      check("midrst_req", mem_req, 1'b0);
      tick();
      mem_ack = 1'b0;
      check("midrst_state", state, 3'd0);
      check("midrst_pc", pc, 32'h0);
      check("midrst_rf_we2", rf_we, 1'b0);
      rst = 1'b0;
      pc_m = 32'h0;
      exp_q.delete();
    end
    // illegal encodings: bad base, then SYSTEM
    for (int t = 0; t < 2; t++) begin
      do_reset();
      issue(5'b00100, 2'b11, 1'b0, 32'h0, 0, 1, 1'b0);
      if (t == 0) issue(5'b00100, 2'b01, 1'b0, 32'h0, 0, 1, 1'b0);
      else        issue(5'b11100, 2'b11, 1'b0, 32'h0, 0, 1, 1'b0);
      for (int i = 0; i < 20; i++) begin
        mem_ack = 1'($urandom_range(0, 1));
        tick();
        check("trap_hold_state", state, 3'd5);
        check("trap_hold_en",
              {mem_req, mem_we, mem_sel, ir_we, rf_we}, 5'd0);
      end
      check("trap_hold_pc", pc, 32'h4);
      check("trap_hold_ill", illegal, 1'b1);
      mem_ack = 1'b0;
    end
    // watchdog: withhold ack in FETCH
    do_reset();
    repeat (254) tick();
    check("wd_pre_state", state, 3'd0);
    check("wd_pre_timeout", timeout, 1'b0);
    tick();
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    check("wd_state", state, 3'd5);
    check("wd_timeout", timeout, 1'b1);
`else
    check("wd_state", state, 3'd0);
    check("wd_timeout", timeout, 1'b0);
`endif
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
